// File: rtl/bip_prog_mem.sv
// BIP instruction memory with a serial byte loader and a registered fetch port.
// Optional build macro BIP_PMEM_CHECKSUM_EN enables the mod-256 byte checksum output.
module bip_prog_mem #(
    parameter int              DATA_W  = 16,
    parameter int              ADDR_W  = 11,
    parameter int              DEPTH   = 2048,
    parameter int              OPC_W   = 5,
    parameter logic [OPC_W-1:0] HLT_OPC = {OPC_W{1'b0}}
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_load_start,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte,
    output logic              o_byte_ready,
    output logic              o_busy,
    output logic              o_load_done,
    output logic              o_overflow,
    output logic [ADDR_W:0]   o_word_count,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_data,
    output logic [7:0]        o_checksum
);

    localparam int BPW    = DATA_W / 8;
    localparam int CNT_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BPW - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_hlt(input logic [DATA_W-1:0] word);
        return word[DATA_W-1 -: OPC_W] == HLT_OPC;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_r;
    logic [CNT_W-1:0]  byte_cnt_r;
    logic [DATA_W-1:0] asm_r;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W:0]   word_count_r;
    logic              overflow_r;
    logic              busy_r;
    logic              ready_r;
    logic              done_r;
    logic [DATA_W-1:0] data_r;

    logic              accept_s;
    logic              word_done_s;
    logic              hlt_s;
    logic              last_slot_s;
    logic              load_entry_s;
    logic              rd_fire_s;
    logic              addr_ok_s;
    logic [DATA_W-1:0] word_s;
    logic [MEM_AW-1:0] rd_idx_s;
    logic [MEM_AW-1:0] wr_idx_s;

    // Byte acceptance, word completion and fetch qualification
    always_comb begin
        accept_s     = i_byte_valid && (state_r == ST_LOAD);
        word_s       = (asm_r << 4'd8) | DATA_W'(i_byte);
        word_done_s  = accept_s && (byte_cnt_r == LAST_BYTE);
        hlt_s        = is_hlt(word_s);
        last_slot_s  = (wr_ptr_r == LAST_ADDR);
        load_entry_s = i_load_start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        rd_fire_s    = i_rd_en && (state_r != ST_LOAD);
        addr_ok_s    = ({1'b0, i_addr} < DEPTH_EXT);
        rd_idx_s     = i_addr[MEM_AW-1:0];
        wr_idx_s     = wr_ptr_r[MEM_AW-1:0];
    end

    // Loader FSM with byte assembly, write pointer and registered status outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r      <= ST_IDLE;
            byte_cnt_r   <= '0;
            asm_r        <= '0;
            wr_ptr_r     <= '0;
            word_count_r <= '0;
            overflow_r   <= 1'b0;
            busy_r       <= 1'b0;
            ready_r      <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (load_entry_s) begin
                        state_r      <= ST_LOAD;
                        byte_cnt_r   <= '0;
                        wr_ptr_r     <= '0;
                        word_count_r <= '0;
                        overflow_r   <= 1'b0;
                        busy_r       <= 1'b1;
                        ready_r      <= 1'b1;
                        done_r       <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        asm_r <= word_s;
                        if (word_done_s) begin
                            byte_cnt_r   <= '0;
                            wr_ptr_r     <= wr_ptr_r + 1'b1;
                            word_count_r <= word_count_r + 1'b1;
                            // A HLT in the last slot is a clean finish, not an overflow
                            if (hlt_s || last_slot_s) begin
                                state_r    <= ST_DONE;
                                overflow_r <= !hlt_s;
                                busy_r     <= 1'b0;
                                ready_r    <= 1'b0;
                                done_r     <= 1'b1;
                            end
                        end else begin
                            byte_cnt_r <= byte_cnt_r + 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Word store; the array is deliberately left out of reset
    always_ff @(posedge CLK) begin
        if (word_done_s) begin
            mem[wr_idx_s] <= word_s;
        end
    end

    // Registered fetch port, out-of-range addresses read as zero
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            data_r <= '0;
        end else if (rd_fire_s) begin
            data_r <= addr_ok_s ? mem[rd_idx_s] : '0;
        end
    end

`ifdef BIP_PMEM_CHECKSUM_EN
    logic [7:0] checksum_r;

    // Running mod-256 sum of the bytes accepted in the current load
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            checksum_r <= 8'h00;
        end else if (load_entry_s) begin
            checksum_r <= 8'h00;
        end else if (accept_s) begin
            checksum_r <= checksum_r + i_byte;
        end
    end

    assign o_checksum = checksum_r;
`else
    assign o_checksum = 8'h00;
`endif

    assign o_byte_ready = ready_r;
    assign o_busy       = busy_r;
    assign o_load_done  = done_r;
    assign o_overflow   = overflow_r;
    assign o_word_count = word_count_r;
    assign o_data       = data_r;

endmodule

// File: tb/tb_bip_prog_mem.sv
// Self-checking bench for bip_prog_mem: directed load/fetch sequences, a fetch vector
// table and randomized loads against a word-level reference model.
`timescale 1ns/1ps
module tb_bip_prog_mem;

`ifdef BIP_PMEM_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif
    localparam int DEPTH_A = 4;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    // instance a: 16-bit words, 4 deep, 3-bit address
    logic        load_start = 1'b0, byte_valid = 1'b0, rd_en = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic [2:0]  addr = 3'd0;
    logic        byte_ready, busy, load_done, overflow;
    logic [3:0]  word_count;
    logic [15:0] data;
    logic [7:0]  checksum;

    // instance b: 32-bit words, 6 deep, 4-bit address
    logic        b_load_start = 1'b0, b_byte_valid = 1'b0, b_rd_en = 1'b0;
    logic [7:0]  b_byte = 8'h00;
    logic [3:0]  b_addr = 4'd0;
    logic        b_byte_ready, b_busy, b_load_done, b_overflow;
    logic [4:0]  b_word_count;
    logic [31:0] b_data;
    logic [7:0]  b_checksum;

    bip_prog_mem #(.DATA_W(16), .ADDR_W(3), .DEPTH(DEPTH_A), .OPC_W(5), .HLT_OPC(5'b0)) dut (
        .CLK(CLK), .RESET(RESET), .i_load_start(load_start), .i_byte_valid(byte_valid),
        .i_byte(byte_in), .o_byte_ready(byte_ready), .o_busy(busy), .o_load_done(load_done),
        .o_overflow(overflow), .o_word_count(word_count), .i_rd_en(rd_en), .i_addr(addr),
        .o_data(data), .o_checksum(checksum));

    bip_prog_mem #(.DATA_W(32), .ADDR_W(4), .DEPTH(6), .OPC_W(5), .HLT_OPC(5'b0)) dut_b (
        .CLK(CLK), .RESET(RESET), .i_load_start(b_load_start), .i_byte_valid(b_byte_valid),
        .i_byte(b_byte), .o_byte_ready(b_byte_ready), .o_busy(b_busy), .o_load_done(b_load_done),
        .o_overflow(b_overflow), .o_word_count(b_word_count), .i_rd_en(b_rd_en), .i_addr(b_addr),
        .o_data(b_data), .o_checksum(b_checksum));

    typedef struct packed {
        logic        rd_en;
        logic [2:0]  addr;
        logic [15:0] exp;
    } rd_vec_t;

    rd_vec_t     rd_tab [8];
    int          tests = 0;
    int          failed = 0;
    logic [15:0] model_mem [DEPTH_A];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in = b;
        step();
        byte_valid = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic read_a(input logic [2:0] a);
        rd_en = 1'b1;
        addr = a;
        step();
        rd_en = 1'b0;
    endtask

    task automatic send_byte_b(input logic [7:0] b);
        b_byte_valid = 1'b1;
        b_byte = b;
        step();
        b_byte_valid = 1'b0;
    endtask

    task automatic send_word_b(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) send_byte_b(w[8*k +: 8]);
    endtask

    task automatic read_b(input logic [3:0] a);
        b_rd_en = 1'b1;
        b_addr = a;
        step();
        b_rd_en = 1'b0;
    endtask

    function automatic logic [7:0] exp_cs(input logic [7:0] sum);
        return CS_EN ? sum : 8'h00;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] words [6];
        int          n, hp, cnt;
        logic        ovf, fin;
        logic [7:0]  cs;

        rd_tab[0] = '{1'b1, 3'd1, 16'h0801};
        rd_tab[1] = '{1'b0, 3'd0, 16'h0801};
        rd_tab[2] = '{1'b1, 3'd4, 16'h0000};
        rd_tab[3] = '{1'b1, 3'd2, 16'h0000};
        rd_tab[4] = '{1'b1, 3'd0, 16'h1803};
        rd_tab[5] = '{1'b1, 3'd7, 16'h0000};
        rd_tab[6] = '{1'b0, 3'd2, 16'h0000};
        rd_tab[7] = '{1'b1, 3'd1, 16'h0801};

        // reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_ready", byte_ready, 0);
        check("rst_done", load_done, 0);
        check("rst_ovf", overflow, 0);
        check("rst_count", word_count, 0);
        check("rst_data", data, 0);
        check("rst_cs", checksum, 0);
        step();
        RESET = 1'b0;
        step();

        // basic load ending in HLT
        start_load();
        check("t1_ready", byte_ready, 1);
        send_byte(8'h18);
        send_byte(8'h03);
        check("t1_count1", word_count, 1);
        send_byte(8'h08); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        check("t1_done", load_done, 1);
        check("t1_busy", busy, 0);
        check("t1_count", word_count, 3);
        check("t1_ovf", overflow, 0);
        check("t1_cs", checksum, exp_cs(8'h24));
        check("t1_data_pre", data, 0);
        read_a(3'd0);
        check("t1_rd0", data, 16'h1803);

        for (int i = 0; i < 8; i++) begin
            rd_en = rd_tab[i].rd_en;
            addr = rd_tab[i].addr;
            step();
            check($sformatf("tab%0d", i), data, rd_tab[i].exp);
        end
        rd_en = 1'b0;

        // byte presented outside LOAD is dropped
        check("t2_ready_idle", byte_ready, 0);
        send_byte(8'h77);
        start_load();
        send_byte(8'h28); send_byte(8'h04); send_byte(8'h00); send_byte(8'h00);
        check("t2_count", word_count, 2);
        read_a(3'd0);
        check("t2_rd0", data, 16'h2804);

        // fetch request during LOAD leaves o_data alone
        start_load();
        send_byte(8'h30); send_byte(8'h07);
        read_a(3'd1);
        check("t5_hold", data, 16'h2804);
        send_byte(8'h00); send_byte(8'h00);
        check("t5_done", load_done, 1);
        read_a(3'd0);
        check("t5_rd0", data, 16'h3007);

        // checksum wraps mod 256
        start_load();
        send_byte(8'hFF); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        check("t6_cs", checksum, exp_cs(8'h01));
        read_a(3'd0);
        check("t6_rd0", data, 16'hFF02);

        // fill memory without HLT -> overflow, extra bytes ignored
        start_load();
        send_byte(8'h08); send_byte(8'h01); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h18); send_byte(8'h03);
        check("t3_count3", word_count, 3);
        check("t3_busy3", busy, 1);
        send_byte(8'h20); send_byte(8'h04);
        check("t3_done", load_done, 1);
        check("t3_ovf", overflow, 1);
        check("t3_count", word_count, 4);
        send_byte(8'h00); send_byte(8'h00);
        check("t3_count_after", word_count, 4);
        check("t3_done_after", load_done, 1);
        check("t3_cs", checksum, exp_cs(8'h5A));
        read_a(3'd3);
        check("t3_rd3", data, 16'h2004);
        model_mem[0] = 16'h0801; model_mem[1] = 16'h1002;
        model_mem[2] = 16'h1803; model_mem[3] = 16'h2004;

        // randomized loads against the word-level model
        for (int it = 0; it < 20; it++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                words[i] = 16'($urandom);
                if (words[i][15:11] == 5'd0) words[i][15:11] = 5'h1F;
            end
            hp = $urandom_range(0, 3) != 0 ? $urandom_range(0, n - 1) : n;
            if (hp < n) words[hp][15:11] = 5'd0;
            else if (n < DEPTH_A) words[n-1][15:11] = 5'd0;

            cnt = 0; ovf = 1'b0; fin = 1'b0; cs = 8'h00;
            for (int i = 0; i < n; i++) begin
                if (!fin) begin
                    model_mem[i] = words[i];
                    cnt++;
                    cs = cs + words[i][15:8] + words[i][7:0];
                    if (words[i][15:11] == 5'd0) fin = 1'b1;
                    else if (cnt == DEPTH_A) begin fin = 1'b1; ovf = 1'b1; end
                end
            end

            if ($urandom_range(0, 1) == 1) send_byte(8'($urandom));
            start_load();
            for (int i = 0; i < n; i++) begin
                for (int k = 1; k >= 0; k--) begin
                    repeat ($urandom_range(0, 2)) step();
                    send_byte(words[i][8*k +: 8]);
                end
            end
            check($sformatf("r%0d_done", it), load_done, 1);
            check($sformatf("r%0d_count", it), word_count, cnt);
            check($sformatf("r%0d_ovf", it), overflow, ovf);
            check($sformatf("r%0d_cs", it), checksum, exp_cs(cs));
            for (int a = 0; a < 8; a++) begin
                repeat ($urandom_range(0, 1)) step();
                read_a(3'(a));
                check($sformatf("r%0d_rd%0d", it, a), data, a < DEPTH_A ? model_mem[a] : 16'h0000);
            end
        end

        // reset in the middle of a 32-bit word
        b_load_start = 1'b1; step(); b_load_start = 1'b0;
        send_word_b(32'h11223344);
        send_word_b(32'h00000000);
        check("t4_first_count", b_word_count, 2);
        read_b(4'd0);
        check("t4_first_rd0", b_data, 32'h11223344);
        b_load_start = 1'b1; step(); b_load_start = 1'b0;
        send_word_b(32'h99AABBCC);
        send_byte_b(8'h55); send_byte_b(8'h66); send_byte_b(8'h77);
        RESET = 1'b1;
        #2;
        check("t4_busy", b_busy, 0);
        check("t4_count", b_word_count, 0);
        check("t4_data", b_data, 0);
        step();
        RESET = 1'b0;
        step();
        read_b(4'd0);
        check("t4_rd0", b_data, 32'h99AABBCC);
        read_b(4'd1);
        check("t4_rd1", b_data, 32'h00000000);
        read_b(4'd0);
        read_b(4'd6);
        check("t4_rd_depth", b_data, 32'h0);
        read_b(4'd0);
        read_b(4'd15);
        check("t4_rd_max", b_data, 32'h0);
        b_load_start = 1'b1; step(); b_load_start = 1'b0;
        send_word_b(32'h00000001);
        check("t4_reload_count", b_word_count, 1);
        check("t4_reload_done", b_load_done, 1);
        read_b(4'd0);
        check("t4_reload_rd0", b_data, 32'h00000001);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
